eth_pixel_receiver: RTL



---
 rtl/eth_rx_pkg.sv | 17 +
 rtl/rmii_byte_assembler.sv | 47 ++++
 rtl/eth_pixel_receiver.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RMII pixel receive path.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DRAIN
    } rx_state_t;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_LAST_DIBIT = 2'b11;

    localparam int unsigned PRE_CNT_W = 6;
    localparam logic [PRE_CNT_W-1:0] PRE_CNT_MAX = '1;

endpackage

// File: rtl/rmii_byte_assembler.sv
// Packs four RMII dibits LSB-first into a byte and pulses byte_valid_o when complete.
module rmii_byte_assembler
    import eth_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       dibit_valid_i,
    input  logic [1:0] rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o
);

    logic [1:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_valid_q, byte_valid_d;

    // New dibits enter at the top so the first one ends up in bits [1:0].
    always_comb begin
        idx_d        = idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        if (clear_i) begin
            idx_d = '0;
        end else if (dibit_valid_i) begin
            shift_d      = {rxd_i, shift_q[7:2]};
            idx_d        = idx_q + 2'd1;
            byte_valid_d = (idx_q == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = byte_valid_q;

endmodule

// File: rtl/eth_pixel_receiver.sv
// RMII receiver: finds preamble/SFD, turns payload bytes into addressed
// frame-buffer pixel writes, and flags frame completion and packet errors.
module eth_pixel_receiver
    import eth_rx_pkg::*;
#(
    parameter int unsigned PIXELS_PER_PACKET   = 320,
    parameter int unsigned FRAME_PIXELS        = 76800,
    parameter int unsigned MIN_PREAMBLE_DIBITS = 8,
    parameter int unsigned ADDR_W              = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              crsdv_in,
    input  logic [1:0]        rxd_in,
    output logic [7:0]        pixel_out,
    output logic [ADDR_W-1:0] pixel_addr_out,
    output logic              pixel_valid_out,
    output logic              frame_done_out,
    output logic              packet_error_out
);

    localparam int unsigned PIX_CNT_W = $clog2(PIXELS_PER_PACKET + 1);
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W-1:0]    FRAME_LEN = ADDR_W'(FRAME_PIXELS);
    localparam logic [ADDR_W-1:0]    PKT_LEN   = ADDR_W'(PIXELS_PER_PACKET);
    localparam logic [PIX_CNT_W-1:0] PKT_PIX   = PIX_CNT_W'(PIXELS_PER_PACKET);
    localparam logic [PRE_CNT_W-1:0] PRE_MIN   = PRE_CNT_W'(MIN_PREAMBLE_DIBITS);

    rx_state_t            state_q, state_d;
    logic [PRE_CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [ADDR_W-1:0]    realign;
    logic [7:0]           pixel_q, pixel_d;
    logic [ADDR_W-1:0]    paddr_q, paddr_d;
    logic                 pvalid_q, pvalid_d;
    logic                 fdone_q, fdone_d;
    logic                 perr_q, perr_d;

    logic [7:0] asm_byte;
    logic       asm_valid;
    logic       asm_clear;

    assign asm_clear = (state_q != PAYLOAD) || !crsdv_in;

    rmii_byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (asm_clear),
        .dibit_valid_i(crsdv_in),
        .rxd_i        (rxd_in),
        .byte_o       (asm_byte),
        .byte_valid_o (asm_valid)
    );

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        pix_cnt_d = pix_cnt_q;
        waddr_d   = waddr_q;
        base_d    = base_q;
        pixel_d   = pixel_q;
        paddr_d   = paddr_q;
        pvalid_d  = 1'b0;
        fdone_d   = 1'b0;
        perr_d    = 1'b0;

        realign = base_q + PKT_LEN;
        if (realign >= FRAME_LEN) begin
            realign = realign - FRAME_LEN;
        end

        // A completed byte is always written, even if carrier drops this cycle.
        if (asm_valid) begin
            pixel_d   = asm_byte;
            paddr_d   = waddr_q;
            pvalid_d  = 1'b1;
            fdone_d   = (waddr_q == LAST_ADDR);
            waddr_d   = (waddr_q == LAST_ADDR) ? '0 : waddr_q + ADDR_W'(1);
            pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
        end

        if (!crsdv_in) begin
            state_d = IDLE;
            if (state_q == PAYLOAD && pix_cnt_d < PKT_PIX) begin
                perr_d  = 1'b1;
                waddr_d = realign;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (rxd_in == PREAMBLE_DIBIT) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = PRE_CNT_W'(1);
                    end else begin
                        state_d = DRAIN;
                    end
                end
                PREAMBLE: begin
                    if (rxd_in == PREAMBLE_DIBIT) begin
                        if (pre_cnt_q != PRE_CNT_MAX) begin
                            pre_cnt_d = pre_cnt_q + PRE_CNT_W'(1);
                        end
                    end else if (rxd_in == SFD_LAST_DIBIT && pre_cnt_q >= PRE_MIN) begin
                        state_d   = PAYLOAD;
                        base_d    = waddr_q;
                        pix_cnt_d = '0;
                    end else begin
                        state_d = DRAIN;
                        perr_d  = 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (pix_cnt_d == PKT_PIX) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    state_d = DRAIN;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            pix_cnt_q <= '0;
            waddr_q   <= '0;
            base_q    <= '0;
            pixel_q   <= '0;
            paddr_q   <= '0;
            pvalid_q  <= 1'b0;
            fdone_q   <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            waddr_q   <= waddr_d;
            base_q    <= base_d;
            pixel_q   <= pixel_d;
            paddr_q   <= paddr_d;
            pvalid_q  <= pvalid_d;
            fdone_q   <= fdone_d;
            perr_q    <= perr_d;
        end
    end

    assign pixel_out        = pixel_q;
    assign pixel_addr_out   = paddr_q;
    assign pixel_valid_out  = pvalid_q;
    assign frame_done_out   = fdone_q;
    assign packet_error_out = perr_q;

endmodule
